// File: rtl/cs_byte_packer.sv
// Byte-stream packer feeding the checksum core: assembles bytes MSB-first into one
// frame and emits it as a single-cycle pulse; in_flush closes a short zero-padded frame.
module cs_byte_packer #(
  parameter int WIDTH_DATA_1 = 384,
  parameter int WIDTH_DATA_2 = 128,
  localparam int FW = WIDTH_DATA_1 + WIDTH_DATA_2,
  localparam int NB = FW / 8,
  localparam int LW = $clog2(NB + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  input  logic          in_flush,
  output logic          out_valid,
  output logic [FW-1:0] data,
  output logic [LW-1:0] out_len,
  output logic          busy
);

  typedef enum logic {EMPTY, FILL} state_e;

  state_e          state_q;
  logic [LW-1:0]   cnt_q;
  logic [FW-1:0]   asm_q;
  logic [FW-1:0]   asm_d;
  logic [LW-1:0]   held_d;
  logic            emit;
  logic            out_valid_q;
  logic [FW-1:0]   data_q;
  logic [LW-1:0]   out_len_q;
  logic            busy_q;

  // Merge this cycle's byte into the assembly image so a flush or the final byte
  // can hand a complete frame to the output register in the same edge.
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < NB; k++) begin
      if (in_valid && (cnt_q == LW'(k))) begin
        asm_d[FW-8-8*k +: 8] = in_byte;
      end
    end
    held_d = cnt_q + LW'(in_valid);
    emit   = (held_d == LW'(NB)) || (in_flush && (held_d != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      out_len_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      out_len_q   <= '0;
      if (emit) begin
        out_valid_q <= 1'b1;
        data_q      <= asm_d;
        out_len_q   <= held_d;
        cnt_q       <= '0;
        asm_q       <= '0;
        busy_q      <= 1'b0;
      end else begin
        cnt_q  <= held_d;
        asm_q  <= asm_d;
        busy_q <= (held_d != '0);
      end
      case (state_q)
        EMPTY: begin
          if (!emit && in_valid) begin
            state_q <= FILL;
          end
        end
        FILL: begin
          if (emit) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign data      = data_q;
  assign out_len   = out_len_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cs_byte_packer.sv
// Self-checking bench for cs_byte_packer: vector table, directed corner sequences and
// random traffic checked against a queue-based model of the packing rules.
module tb_cs_byte_packer;
  localparam int FW = 512;
  localparam int NB = 64;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_flush = 1'b0;
  logic          out_valid;
  logic [FW-1:0] data;
  logic [LW-1:0] out_len;
  logic          busy;

  cs_byte_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
    .in_flush(in_flush), .out_valid(out_valid), .data(data),
    .out_len(out_len), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int dutPulses[$];
  logic [FW-1:0] lastData = '0;
  logic [LW-1:0] lastLen = '0;

  // Reference model: bytes currently held, and the expected registered outputs.
  logic [7:0]    held[$];
  logic          expValid = 1'b0;
  logic [FW-1:0] expData = '0;
  logic [LW-1:0] expLen = '0;

  typedef struct {
    logic          v;
    logic [7:0]    b;
    logic          f;
    logic          expValid;
    logic [LW-1:0] expLen;
    logic          expBusy;
    logic [7:0]    expTop;
  } vec_t;
  vec_t vecs[10];

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] buildFrame();
    logic [FW-1:0] f = '0;
    for (int i = 0; i < held.size(); i++) f[FW-1-8*i -: 8] = held[i];
    return f;
  endfunction

  task automatic checkOutput();
    check("out_valid", FW'(out_valid), FW'(expValid));
    check("data", data, expData);
    check("out_len", FW'(out_len), FW'(expLen));
    check("busy", FW'(busy), FW'(held.size() != 0));
    if (out_valid === 1'b1) begin
      dutPulses.push_back(cycle);
      lastData = data;
      lastLen  = out_len;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic f);
    @(negedge clk);
    in_valid = v;
    in_byte  = b;
    in_flush = f;
    @(posedge clk);
    if (v) held.push_back(b);
    if (held.size() == NB || (f && held.size() > 0)) begin
      expValid = 1'b1;
      expData  = buildFrame();
      expLen   = LW'(held.size());
      held.delete();
    end else begin
      expValid = 1'b0;
      expData  = '0;
      expLen   = '0;
    end
    #1 checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_flush = 1'b0;
    in_byte  = 8'h00;
    held.delete();
    expValid = 1'b0;
    expData  = '0;
    expLen   = '0;
    #1;
    check("rst_out_valid", FW'(out_valid), '0);
    check("rst_data", data, '0);
    check("rst_out_len", FW'(out_len), '0);
    check("rst_busy", FW'(busy), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [FW-1:0] rampFrame;
    logic [FW-1:0] aaFrame;
    logic [FW-1:0] c3Frame;
    int idx;

    rampFrame = '0;
    for (int i = 0; i < NB; i++) begin
      rampFrame[FW-1-8*i -: 8] = 8'(i);
      aaFrame[FW-1-8*i -: 8]   = 8'hAA;
      c3Frame[FW-1-8*i -: 8]   = 8'hC3;
    end

    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 7'd0, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 7'd0, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 7'd0, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 7'd3, 1'b0, 8'h11};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 8'h7E, 1'b1, 1'b1, 7'd1, 1'b0, 8'h7E};
    vecs[6] = '{1'b1, 8'h7E, 1'b1, 1'b1, 7'd1, 1'b0, 8'h7E};
    vecs[7] = '{1'b1, 8'hA5, 1'b0, 1'b0, 7'd0, 1'b1, 8'h00};
    vecs[8] = '{1'b0, 8'h5A, 1'b0, 1'b0, 7'd0, 1'b1, 8'h00};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 7'd1, 1'b0, 8'hA5};

    doReset();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].v, vecs[i].b, vecs[i].f);
      check($sformatf("tbl%0d_valid", i), FW'(out_valid), FW'(vecs[i].expValid));
      check($sformatf("tbl%0d_len", i), FW'(out_len), FW'(vecs[i].expLen));
      check($sformatf("tbl%0d_busy", i), FW'(busy), FW'(vecs[i].expBusy));
      check($sformatf("tbl%0d_top", i), FW'(data[FW-1 -: 8]), FW'(vecs[i].expTop));
      if (i == 3) check("tbl_short_frame", data, {8'h11, 8'h22, 8'h33, 488'd0});
    end

    dutPulses.delete();
    for (int i = 0; i < NB; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    check("ramp_pulses", FW'(dutPulses.size()), FW'(1));
    check("ramp_data", lastData, rampFrame);
    check("ramp_len", FW'(lastLen), FW'(NB));
    applyStimulus(1'b0, 8'h00, 1'b0);
    check("ramp_busy_after", FW'(busy), '0);

    dutPulses.delete();
    for (int i = 0; i < NB; i++) applyStimulus(1'b1, 8'hAA, 1'b0);
    check("b2b_first", lastData, aaFrame);
    for (int i = 0; i < NB; i++) applyStimulus(1'b1, 8'h55, 1'b0);
    check("b2b_pulses", FW'(dutPulses.size()), FW'(2));
    if (dutPulses.size() == 2)
      check("b2b_spacing", FW'(dutPulses[1] - dutPulses[0]), FW'(NB));
    check("b2b_second", lastData, {NB{8'h55}});

    dutPulses.delete();
    for (int i = 0; i < NB - 1; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b1, 8'h3F, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    check("flush64_pulses", FW'(dutPulses.size()), FW'(1));
    check("flush64_data", lastData, rampFrame);
    check("flush64_len", FW'(lastLen), FW'(NB));

    dutPulses.delete();
    idx = 0;
    while (idx < NB) begin
      if ($urandom_range(3) == 0) begin
        applyStimulus(1'b0, 8'($urandom), 1'b0);
      end else begin
        applyStimulus(1'b1, 8'(idx), 1'b0);
        idx++;
      end
    end
    check("gap_pulses", FW'(dutPulses.size()), FW'(1));
    check("gap_data", lastData, rampFrame);

    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    dutPulses.delete();
    doReset();
    for (int i = 0; i < NB; i++) applyStimulus(1'b1, 8'hC3, 1'b0);
    check("rst_mid_pulses", FW'(dutPulses.size()), FW'(1));
    check("rst_mid_data", lastData, c3Frame);
    check("rst_mid_len", FW'(lastLen), FW'(NB));

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(3) != 0, 8'($urandom), $urandom_range(15) == 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
